// File: rtl/ikaopll_output_accumulator_if.sv
// Bus between the IKAOPLL timing generator side and the output accumulator.
// o_SAMPLE_VALID is a one-clock strobe with no ready: the consumer must capture o_MELODY/o_RHYTHM/o_MIX while it is high.
interface ikaopll_output_accumulator_if #(
    parameter int OUT_WIDTH = 16
);
    logic                        i_phi1_NCEN_n;
    logic                        i_DAC_EN;
    logic                        i_MO_CTRL;
    logic                        i_RO_CTRL;
    logic                        i_CYCLE_00;
    logic [8:0]                  i_OP_VALUE;
    logic                        i_ERR_CLR;
    logic signed [12:0]          o_MELODY;
    logic signed [12:0]          o_RHYTHM;
    logic signed [OUT_WIDTH-1:0] o_MIX;
    logic                        o_SAMPLE_VALID;
    logic                        o_LOCKED;
    logic                        o_FRAME_ERR;
    logic [1:0]                  o_STATE;

    modport master (
        output i_phi1_NCEN_n, i_DAC_EN, i_MO_CTRL, i_RO_CTRL, i_CYCLE_00, i_OP_VALUE, i_ERR_CLR,
        input  o_MELODY, o_RHYTHM, o_MIX, o_SAMPLE_VALID, o_LOCKED, o_FRAME_ERR, o_STATE
    );

    modport slave (
        input  i_phi1_NCEN_n, i_DAC_EN, i_MO_CTRL, i_RO_CTRL, i_CYCLE_00, i_OP_VALUE, i_ERR_CLR,
        output o_MELODY, o_RHYTHM, o_MIX, o_SAMPLE_VALID, o_LOCKED, o_FRAME_ERR, o_STATE
    );
endinterface

// File: rtl/ikaopll_output_accumulator.sv
// Sums per-slot operator outputs of an 18-step frame into melody/rhythm accumulators and
// publishes signed samples at each frame boundary, while tracking frame lock and framing errors.
module ikaopll_output_accumulator #(
    parameter int OUT_WIDTH         = 16,
    parameter int RHYTHM_GAIN_SHIFT = 1
) (
    input  logic                          i_EMUCLK,
    input  logic                          i_RST,
    ikaopll_output_accumulator_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [4:0] LAST_STEP = 5'd17;
    localparam logic [4:0] CNT_MAX   = 5'd31;

    logic [1:0]               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic signed [12:0]       mel_acc_q, mel_acc_d;
    logic signed [12:0]       rhy_acc_q, rhy_acc_d;
    logic signed [12:0]       melody_q, melody_d;
    logic signed [12:0]       rhythm_q, rhythm_d;
    logic signed [OUT_WIDTH-1:0] mix_q, mix_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;

    logic                     step;
    logic                     publish;
    logic                     err_event;
    logic signed [12:0]       mag13;
    logic signed [12:0]       contrib;
    logic signed [12:0]       rhy_contrib;
    logic signed [12:0]       mel_add;
    logic signed [12:0]       rhy_add;
    logic signed [13:0]       mix_sum;
    logic signed [OUT_WIDTH-1:0] mix_next;

    assign step = ~bus.i_phi1_NCEN_n;

    // 14-bit sum cannot overflow; clip to the 13-bit range whenever the top two bits disagree.
    function automatic logic signed [12:0] sat_add13(input logic signed [12:0] a,
                                                     input logic signed [12:0] b);
        logic signed [13:0] s;
        s = {a[12], a} + {b[12], b};
        if (s[13] != s[12])
            sat_add13 = s[13] ? 13'sh1000 : 13'sh0FFF;
        else
            sat_add13 = s[12:0];
    endfunction

    always_comb begin
        mag13   = {5'b00000, bus.i_OP_VALUE[7:0]};
        contrib = 13'sd0;
        if (bus.i_DAC_EN)
            contrib = bus.i_OP_VALUE[8] ? -mag13 : mag13;
        rhy_contrib = contrib <<< RHYTHM_GAIN_SHIFT;
        mel_add     = bus.i_MO_CTRL ? contrib : 13'sd0;
        rhy_add     = bus.i_RO_CTRL ? rhy_contrib : 13'sd0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mel_acc_d = mel_acc_q;
        rhy_acc_d = rhy_acc_q;
        publish   = 1'b0;
        err_event = 1'b0;
        if (step) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_CYCLE_00) begin
                        mel_acc_d = mel_add;
                        rhy_acc_d = rhy_add;
                        cnt_d     = 5'd0;
                        state_d   = ST_ACQ;
                    end
                end
                ST_ACQ, ST_RUN: begin
                    if (bus.i_CYCLE_00) begin
                        if (cnt_q == LAST_STEP) begin
                            publish = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            err_event = 1'b1;
                            state_d   = ST_ACQ;
                        end
                        // The boundary step's own contribution opens the next frame.
                        mel_acc_d = mel_add;
                        rhy_acc_d = rhy_add;
                        cnt_d     = 5'd0;
                    end else begin
                        mel_acc_d = sat_add13(mel_acc_q, mel_add);
                        rhy_acc_d = sat_add13(rhy_acc_q, rhy_add);
                        cnt_d     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    mel_acc_d = 13'sd0;
                    rhy_acc_d = 13'sd0;
                    cnt_d     = 5'd0;
                end
            endcase
        end
    end

    assign mix_sum = {mel_acc_q[12], mel_acc_q} + {rhy_acc_q[12], rhy_acc_q};

    generate
        if (OUT_WIDTH >= 14) begin : g_mix_ext
            assign mix_next = OUT_WIDTH'(mix_sum);
        end else begin : g_mix_sat
            localparam logic signed [13:0] SAT_MAX = 14'((1 << (OUT_WIDTH - 1)) - 1);
            localparam logic signed [13:0] SAT_MIN = -SAT_MAX;
            always_comb begin
                if (mix_sum > SAT_MAX)
                    mix_next = SAT_MAX[OUT_WIDTH-1:0];
                else if (mix_sum < SAT_MIN)
                    mix_next = SAT_MIN[OUT_WIDTH-1:0];
                else
                    mix_next = mix_sum[OUT_WIDTH-1:0];
            end
        end
    endgenerate

    always_comb begin
        melody_d = melody_q;
        rhythm_d = rhythm_q;
        mix_d    = mix_q;
        if (publish) begin
            melody_d = mel_acc_q;
            rhythm_d = rhy_acc_q;
            mix_d    = mix_next;
        end
        valid_d = publish;
        // A new framing error outranks a simultaneous clear.
        if (err_event)
            err_d = 1'b1;
        else if (bus.i_ERR_CLR)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            mel_acc_q <= 13'sd0;
            rhy_acc_q <= 13'sd0;
            melody_q  <= 13'sd0;
            rhythm_q  <= 13'sd0;
            mix_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mel_acc_q <= mel_acc_d;
            rhy_acc_q <= rhy_acc_d;
            melody_q  <= melody_d;
            rhythm_q  <= rhythm_d;
            mix_q     <= mix_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_MELODY       = melody_q;
    assign bus.o_RHYTHM       = rhythm_q;
    assign bus.o_MIX          = mix_q;
    assign bus.o_SAMPLE_VALID = valid_q;
    assign bus.o_LOCKED       = (state_q == ST_RUN);
    assign bus.o_FRAME_ERR    = err_q;
    assign bus.o_STATE        = state_q;
endmodule

// File: tb/tb_ikaopll_output_accumulator.sv
// Directed bench for ikaopll_output_accumulator: a 16-bit-mix and a 12-bit-mix instance share one stimulus.
module tb_ikaopll_output_accumulator;
    logic clk;
    logic rst;
    logic err_clr;

    ikaopll_output_accumulator_if #(.OUT_WIDTH(16)) bus16 ();
    ikaopll_output_accumulator_if #(.OUT_WIDTH(12)) bus12 ();

    ikaopll_output_accumulator #(.OUT_WIDTH(16), .RHYTHM_GAIN_SHIFT(1)) u_dut16 (
        .i_EMUCLK (clk),
        .i_RST    (rst),
        .bus      (bus16)
    );

    ikaopll_output_accumulator #(.OUT_WIDTH(12), .RHYTHM_GAIN_SHIFT(1)) u_dut12 (
        .i_EMUCLK (clk),
        .i_RST    (rst),
        .bus      (bus12)
    );

    int n_cmp;
    int n_err;

    // Reference model: 0=IDLE 1=ACQ 2=RUN
    int m_state;
    int m_cnt;
    int m_acc;
    int r_acc;
    bit m_err;
    logic [53:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int sat13(input int x);
        if (x > 4095) return 4095;
        if (x < -4096) return -4096;
        return x;
    endfunction

    function automatic int clip_sym(input int x, input int lim);
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic nc, input logic dac, input logic mo, input logic ro,
                              input logic c00, input logic [8:0] v);
        bus16.i_phi1_NCEN_n = nc;  bus12.i_phi1_NCEN_n = nc;
        bus16.i_DAC_EN      = dac; bus12.i_DAC_EN      = dac;
        bus16.i_MO_CTRL     = mo;  bus12.i_MO_CTRL     = mo;
        bus16.i_RO_CTRL     = ro;  bus12.i_RO_CTRL     = ro;
        bus16.i_CYCLE_00    = c00; bus12.i_CYCLE_00    = c00;
        bus16.i_OP_VALUE    = v;   bus12.i_OP_VALUE    = v;
        bus16.i_ERR_CLR     = err_clr;
        bus12.i_ERR_CLR     = err_clr;
    endtask

    task automatic check_outputs(input bit pub);
        logic [53:0] e;
        check("valid16", bus16.o_SAMPLE_VALID, pub);
        check("valid12", bus12.o_SAMPLE_VALID, pub);
        check("locked", bus16.o_LOCKED, (m_state == 2));
        check("frame_err", bus16.o_FRAME_ERR, m_err);
        if (pub) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("melody", bus16.o_MELODY, $signed(e[53:41]));
                check("rhythm", bus16.o_RHYTHM, $signed(e[40:28]));
                check("mix16", bus16.o_MIX, $signed(e[27:12]));
                check("mix12", bus12.o_MIX, $signed(e[11:0]));
            end
        end
    endtask

    // One enabled step: advance the model, push the expected sample on publish, then compare.
    task automatic step(input logic dac, input logic mo, input logic ro, input logic c00, input logic [8:0] v);
        int c, mc, rc, s, mag;
        bit pub, err_ev;
        pub = 0;
        err_ev = 0;
        mag = int'(v[7:0]);
        c = 0;
        if (dac) c = v[8] ? -mag : mag;
        mc = mo ? c : 0;
        rc = ro ? c * 2 : 0;
        if (m_state == 0) begin
            if (c00) begin
                m_acc = mc; r_acc = rc; m_cnt = 0; m_state = 1;
            end
        end else if (c00) begin
            if (m_cnt == 17) begin
                s = m_acc + r_acc;
                exp_q.push_back({13'(m_acc), 13'(r_acc), 16'(s), 12'(clip_sym(s, 2047))});
                pub = 1;
                m_state = 2;
            end else begin
                err_ev = 1;
                m_state = 1;
            end
            m_acc = mc; r_acc = rc; m_cnt = 0;
        end else begin
            m_acc = sat13(m_acc + mc);
            r_acc = sat13(r_acc + rc);
            if (m_cnt < 31) m_cnt++;
        end
        if (err_ev) m_err = 1;
        else if (err_clr) m_err = 0;
        set_inputs(1'b0, dac, mo, ro, c00, v);
        @(posedge clk);
        #1;
        check_outputs(pub);
        set_inputs(1'b1, dac, mo, ro, c00, v);
    endtask

    task automatic idle_clocks(input int n);
        logic [8:0] rv;
        for (int i = 0; i < n; i++) begin
            rv = 9'($urandom_range(0, 511));
            set_inputs(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv);
            @(posedge clk);
            #1;
            check("idle_valid", bus16.o_SAMPLE_VALID, 0);
        end
        check("idle_locked", bus16.o_LOCKED, (m_state == 2));
        check("idle_err", bus16.o_FRAME_ERR, m_err);
    endtask

    task automatic run_frame(input int len, input logic dac, input logic [8:0] val, input logic mo,
                             input logic ro, input int ro_cnt, input int gap_at);
        for (int i = 0; i < len; i++) begin
            step(dac, mo, (ro && (i < ro_cnt)), (i == 0), val);
            if (i == gap_at) idle_clocks(100);
        end
    endtask

    task automatic run_frame_rand(input int len);
        for (int i = 0; i < len; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 (i == 0), 9'($urandom_range(0, 511)));
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
        @(posedge clk);
        #1;
        m_err = 0;
        check("err_clear", bus16.o_FRAME_ERR, 0);
        err_clr = 1'b0;
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_acc = 0; r_acc = 0; m_err = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        err_clr = 1'b0;
        model_reset();
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_melody", bus16.o_MELODY, 0);
        check("rst_rhythm", bus16.o_RHYTHM, 0);
        check("rst_mix", bus16.o_MIX, 0);
        check("rst_valid", bus16.o_SAMPLE_VALID, 0);
        check("rst_locked", bus16.o_LOCKED, 0);
        check("rst_err", bus16.o_FRAME_ERR, 0);

        // Melody: three frames of +10
        for (int f = 0; f < 3; f++) run_frame(18, 1'b1, 9'd10, 1'b1, 1'b0, 0, -1);
        check("t1_melody_180", bus16.o_MELODY, 180);
        check("t1_locked", bus16.o_LOCKED, 1);

        // Rhythm: -255 on 5 steps, gain shift 1
        run_frame(18, 1'b1, 9'h1FF, 1'b0, 1'b1, 5, -1);
        // Saturation: +255 everywhere into both accumulators
        run_frame(18, 1'b1, 9'h0FF, 1'b1, 1'b1, 18, -1);
        check("t2_rhythm", bus16.o_RHYTHM, -2550);
        check("t2_mix16", bus16.o_MIX, -2550);
        check("t2_melody", bus16.o_MELODY, 0);

        // Short frame then recovery
        run_frame(12, 1'b1, 9'd3, 1'b1, 1'b0, 0, -1);
        check("t3_melody_clip", bus16.o_MELODY, 4095);
        check("t3_rhythm_clip", bus16.o_RHYTHM, 4095);
        check("t3_mix16", bus16.o_MIX, 8190);
        check("t3_mix12_clip", bus12.o_MIX, 2047);
        run_frame(18, 1'b1, 9'd3, 1'b1, 1'b0, 0, -1);
        check("t4_err_set", bus16.o_FRAME_ERR, 1);
        check("t4_unlocked", bus16.o_LOCKED, 0);
        run_frame_rand(18);
        check("t4_relock", bus16.o_LOCKED, 1);
        check("t4_republish", bus16.o_MELODY, 54);
        clr_err();

        // Error and clear on the same step: error must win on that step
        run_frame(5, 1'b1, 9'd1, 1'b1, 1'b1, 5, -1);
        err_clr = 1'b1;
        run_frame(18, 1'b1, 9'h1F0, 1'b1, 1'b0, 0, -1);
        err_clr = 1'b0;
        run_frame_rand(18);

        // Enable gating, DAC_EN=0 and negative zero
        run_frame(18, 1'b1, 9'd7, 1'b1, 1'b0, 0, 9);
        run_frame(18, 1'b0, 9'h0FF, 1'b1, 1'b1, 18, -1);
        check("t5_gap_melody", bus16.o_MELODY, 126);
        run_frame(18, 1'b1, 9'h100, 1'b1, 1'b1, 18, -1);
        check("t5_dac_off_melody", bus16.o_MELODY, 0);
        check("t5_dac_off_rhythm", bus16.o_RHYTHM, 0);
        run_frame(18, 1'b1, 9'd1, 1'b1, 1'b0, 0, -1);
        check("t5_negzero_melody", bus16.o_MELODY, 0);
        check("t5_negzero_rhythm", bus16.o_RHYTHM, 0);

        // Reset mid-frame
        run_frame(7, 1'b1, 9'd20, 1'b1, 1'b1, 7, -1);
        rst = 1'b1;
        #2;
        model_reset();
        check("t6_rst_melody", bus16.o_MELODY, 0);
        check("t6_rst_rhythm", bus16.o_RHYTHM, 0);
        check("t6_rst_mix", bus16.o_MIX, 0);
        check("t6_rst_locked", bus16.o_LOCKED, 0);
        check("t6_rst_valid", bus16.o_SAMPLE_VALID, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(18, 1'b1, 9'd1, 1'b1, 1'b0, 0, -1);
        check("t6_acq_melody", bus16.o_MELODY, 0);
        check("t6_acq_locked", bus16.o_LOCKED, 0);
        run_frame(18, 1'b1, 9'd1, 1'b1, 1'b0, 0, -1);
        check("t6_first_publish", bus16.o_MELODY, 18);
        check("t6_locked", bus16.o_LOCKED, 1);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
